// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - CDB arbiter source, ROB stall and broadcast signal bundle
interface cdb_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 6,
    parameter int TAG_W  = 6
);
    logic              valid_int2cdb;
    logic [DATA_W-1:0] result_int2cdb;
    logic [REG_W-1:0]  rd_int2cdb;
    logic [TAG_W-1:0]  tag_int2cdb;
    logic              stop_cdb2int;

    logic              valid_ls2cdb;
    logic [DATA_W-1:0] result_ls2cdb;
    logic [REG_W-1:0]  rd_ls2cdb;
    logic [TAG_W-1:0]  tag_ls2cdb;
    logic              stop_cdb2ls;

    logic              stop_rob2cdb;

    logic              valid_cdb;
    logic [DATA_W-1:0] result_cdb;
    logic [REG_W-1:0]  rd_cdb;
    logic [TAG_W-1:0]  tag_cdb;
    logic              src_cdb;

    modport slave (
        input  valid_int2cdb, result_int2cdb, rd_int2cdb, tag_int2cdb,
        input  valid_ls2cdb, result_ls2cdb, rd_ls2cdb, tag_ls2cdb,
        input  stop_rob2cdb,
        output stop_cdb2int, stop_cdb2ls,
        output valid_cdb, result_cdb, rd_cdb, tag_cdb, src_cdb
    );

    modport master (
        output valid_int2cdb, result_int2cdb, rd_int2cdb, tag_int2cdb,
        output valid_ls2cdb, result_ls2cdb, rd_ls2cdb, tag_ls2cdb,
        output stop_rob2cdb,
        input  stop_cdb2int, stop_cdb2ls,
        input  valid_cdb, result_cdb, rd_cdb, tag_cdb, src_cdb
    );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB arbiter with per-source skid FIFOs; CDB_PERF_CNT_EN adds perf counters
module cdb_arbiter #(
    parameter int DATA_W     = 64,
    parameter int REG_W      = 6,
    parameter int TAG_W      = 6,
    parameter int FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          res,
    cdb_arbiter_if.slave  bus
`ifdef CDB_PERF_CNT_EN
    ,
    output logic [31:0]   bcast_int_cnt,
    output logic [31:0]   bcast_ls_cnt,
    output logic [31:0]   stall_cnt
`endif
);
    localparam int E_W = DATA_W + REG_W + TAG_W;
    localparam int P_W = $clog2(FIFO_DEPTH);
    localparam int C_W = P_W + 1;
    localparam logic [C_W-1:0] FULL_CNT = C_W'(FIFO_DEPTH);

    // Index 0 is the INT source, index 1 the LS source throughout.
    logic [E_W-1:0] r_mem [2][FIFO_DEPTH];
    logic [P_W-1:0] r_wr  [2];
    logic [P_W-1:0] r_rd  [2];
    logic [C_W-1:0] r_cnt [2];
    logic           r_rr_last;
    logic           r_valid;
    logic           r_src;
    logic [E_W-1:0] r_out;

    logic [E_W-1:0] w_in_data   [2];
    logic [E_W-1:0] w_cand_data [2];
    logic [1:0]     w_in_valid;
    logic [1:0]     w_full;
    logic [1:0]     w_acc;
    logic [1:0]     w_has_q;
    logic [1:0]     w_cand;
    logic [1:0]     w_pop;
    logic [1:0]     w_bypass;
    logic [1:0]     w_push;
    logic           w_load;
    logic           w_grant;
    logic           w_winner;
    logic [E_W-1:0] w_win_data;

    assign w_in_valid   = {bus.valid_ls2cdb, bus.valid_int2cdb};
    assign w_in_data[0] = {bus.result_int2cdb, bus.rd_int2cdb, bus.tag_int2cdb};
    assign w_in_data[1] = {bus.result_ls2cdb, bus.rd_ls2cdb, bus.tag_ls2cdb};

    // Per-source accept and candidate: the queued head has priority over the live input to keep order.
    always_comb begin
        w_full        = '0;
        w_acc         = '0;
        w_has_q       = '0;
        w_cand        = '0;
        w_cand_data[0] = '0;
        w_cand_data[1] = '0;
        for (int s = 0; s < 2; s++) begin
            w_full[s]      = (r_cnt[s] == FULL_CNT);
            w_acc[s]       = w_in_valid[s] && !w_full[s];
            w_has_q[s]     = (r_cnt[s] != '0);
            w_cand[s]      = w_has_q[s] || w_acc[s];
            w_cand_data[s] = w_has_q[s] ? r_mem[s][r_rd[s]] : w_in_data[s];
        end
    end

    // Grant: the output register only advances when empty or the ROB is not stalling.
    always_comb begin
        w_load     = !r_valid || !bus.stop_rob2cdb;
        w_grant    = w_load && (|w_cand);
        w_winner   = (&w_cand) ? ~r_rr_last : w_cand[1];
        w_win_data = w_winner ? w_cand_data[1] : w_cand_data[0];
    end

    // FIFO control: granted head pops, granted empty source consumes its input directly, else it queues.
    always_comb begin
        w_pop    = '0;
        w_bypass = '0;
        w_push   = '0;
        for (int s = 0; s < 2; s++) begin
            w_pop[s]    = w_grant && (w_winner == 1'(s)) && w_has_q[s];
            w_bypass[s] = w_grant && (w_winner == 1'(s)) && !w_has_q[s];
            w_push[s]   = w_acc[s] && !w_bypass[s];
        end
    end

    // Skid FIFO pointers, counts and storage; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (res) begin
            for (int s = 0; s < 2; s++) begin
                r_wr[s]  <= '0;
                r_rd[s]  <= '0;
                r_cnt[s] <= '0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (w_push[s]) begin
                    r_mem[s][r_wr[s]] <= w_in_data[s];
                    r_wr[s]           <= r_wr[s] + 1'b1;
                end
                if (w_pop[s]) begin
                    r_rd[s] <= r_rd[s] + 1'b1;
                end
                if (w_push[s] && !w_pop[s]) begin
                    r_cnt[s] <= r_cnt[s] + 1'b1;
                end else if (!w_push[s] && w_pop[s]) begin
                    r_cnt[s] <= r_cnt[s] - 1'b1;
                end
            end
        end
    end

    // Broadcast register and round-robin pointer; rr_last starts at LS so INT wins the first tie.
    always_ff @(posedge clk) begin
        if (res) begin
            r_valid   <= 1'b0;
            r_out     <= '0;
            r_src     <= 1'b0;
            r_rr_last <= 1'b1;
        end else if (w_load) begin
            if (w_grant) begin
                r_valid   <= 1'b1;
                r_out     <= w_win_data;
                r_src     <= w_winner;
                r_rr_last <= w_winner;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.stop_cdb2int = w_full[0];
    assign bus.stop_cdb2ls  = w_full[1];
    assign bus.valid_cdb    = r_valid;
    assign bus.src_cdb      = r_src;
    assign {bus.result_cdb, bus.rd_cdb, bus.tag_cdb} = r_out;

`ifdef CDB_PERF_CNT_EN
    logic [31:0] r_bcast_int_cnt;
    logic [31:0] r_bcast_ls_cnt;
    logic [31:0] r_stall_cnt;

    // Grant and ROB-stall counters; they wrap on overflow.
    always_ff @(posedge clk) begin
        if (res) begin
            r_bcast_int_cnt <= '0;
            r_bcast_ls_cnt  <= '0;
            r_stall_cnt     <= '0;
        end else begin
            if (w_grant && !w_winner) r_bcast_int_cnt <= r_bcast_int_cnt + 32'd1;
            if (w_grant &&  w_winner) r_bcast_ls_cnt  <= r_bcast_ls_cnt + 32'd1;
            if (r_valid && bus.stop_rob2cdb) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bcast_int_cnt = r_bcast_int_cnt;
    assign bcast_ls_cnt  = r_bcast_ls_cnt;
    assign stall_cnt     = r_stall_cnt;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized and directed bench for cdb_arbiter against a queue-based model
module tb_cdb_arbiter;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [63:0] r;
        logic [5:0]  rd;
        logic [5:0]  tag;
    } beat_t;

    logic clk = 1'b0;
    logic res;
    always #5 clk = ~clk;

    cdb_arbiter_if bus ();

`ifdef CDB_PERF_CNT_EN
    logic [31:0] bcast_int_cnt, bcast_ls_cnt, stall_cnt;
`endif

    cdb_arbiter #(.DATA_W(64), .REG_W(6), .TAG_W(6), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
`ifdef CDB_PERF_CNT_EN
        ,
        .bcast_int_cnt (bcast_int_cnt),
        .bcast_ls_cnt  (bcast_ls_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Beats waiting at each producer (held until accepted), and beats the arbiter has taken but not yet broadcast.
    beat_t pend_i[$], pend_l[$];
    beat_t q_i[$], q_l[$];
    bit    m_valid, m_src, m_rr;
    beat_t m_out;
    int unsigned m_ci, m_cl, m_cs;
    logic [6:0] log_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q_i.delete(); q_l.delete();
        pend_i.delete(); pend_l.delete();
        m_valid = 0; m_src = 0; m_rr = 1; m_out = '0;
        m_ci = 0; m_cl = 0; m_cs = 0;
    endfunction

    function automatic beat_t rnd_beat(input logic [5:0] tag);
        beat_t b;
        b.r   = {$urandom, $urandom};
        b.rd  = 6'($urandom);
        b.tag = tag;
        return b;
    endfunction

    // One clock: compare visible outputs to the model, drive inputs, advance the model across the edge.
    task automatic step(input bit rob_stop, input bit do_res);
        beat_t bi, bl, item;
        bit vi, vl, ai, al, ci, cl, g, byp_i, byp_l;
        check("valid_cdb",  64'(bus.valid_cdb),  64'(m_valid));
        check("result_cdb", bus.result_cdb,      m_out.r);
        check("rd_cdb",     64'(bus.rd_cdb),     64'(m_out.rd));
        check("tag_cdb",    64'(bus.tag_cdb),    64'(m_out.tag));
        check("src_cdb",    64'(bus.src_cdb),    64'(m_src));
        check("stop_int",   64'(bus.stop_cdb2int), 64'(q_i.size() == DEPTH));
        check("stop_ls",    64'(bus.stop_cdb2ls),  64'(q_l.size() == DEPTH));
`ifdef CDB_PERF_CNT_EN
        check("int_cnt",   64'(bcast_int_cnt), 64'(m_ci));
        check("ls_cnt",    64'(bcast_ls_cnt),  64'(m_cl));
        check("stall_cnt", 64'(stall_cnt),     64'(m_cs));
`endif
        if (bus.valid_cdb) log_q.push_back({bus.src_cdb, bus.tag_cdb});

        vi = !do_res && pend_i.size() > 0;
        vl = !do_res && pend_l.size() > 0;
        bi = vi ? pend_i[0] : rnd_beat(6'($urandom));
        bl = vl ? pend_l[0] : rnd_beat(6'($urandom));
        res = do_res;
        bus.valid_int2cdb = vi; bus.result_int2cdb = bi.r; bus.rd_int2cdb = bi.rd; bus.tag_int2cdb = bi.tag;
        bus.valid_ls2cdb  = vl; bus.result_ls2cdb  = bl.r; bus.rd_ls2cdb  = bl.rd; bus.tag_ls2cdb  = bl.tag;
        bus.stop_rob2cdb  = rob_stop;

        if (do_res) begin
            model_reset();
        end else begin
            ai = vi && q_i.size() < DEPTH;
            al = vl && q_l.size() < DEPTH;
            ci = q_i.size() > 0 || ai;
            cl = q_l.size() > 0 || al;
            byp_i = 0; byp_l = 0;
            if (m_valid && rob_stop) m_cs++;
            if (!m_valid || !rob_stop) begin
                if (ci || cl) begin
                    g = (ci && cl) ? !m_rr : cl;
                    if (!g) begin
                        if (q_i.size() > 0) item = q_i.pop_front();
                        else begin item = bi; byp_i = 1; end
                        m_ci++;
                    end else begin
                        if (q_l.size() > 0) item = q_l.pop_front();
                        else begin item = bl; byp_l = 1; end
                        m_cl++;
                    end
                    m_out = item; m_src = g; m_valid = 1; m_rr = g;
                end else begin
                    m_valid = 0;
                end
            end
            if (ai && !byp_i) q_i.push_back(bi);
            if (al && !byp_l) q_l.push_back(bl);
            if (ai) pend_i.delete(0);
            if (al) pend_l.delete(0);
        end
        @(negedge clk);
    endtask

    function automatic beat_t mk(input logic [63:0] r, input logic [5:0] rd, input logic [5:0] tag);
        beat_t b;
        b.r = r; b.rd = rd; b.tag = tag;
        return b;
    endfunction

    initial begin
        logic [6:0] got;
        res = 1'b1;
        bus.valid_int2cdb = 0; bus.result_int2cdb = '0; bus.rd_int2cdb = '0; bus.tag_int2cdb = '0;
        bus.valid_ls2cdb  = 0; bus.result_ls2cdb  = '0; bus.rd_ls2cdb  = '0; bus.tag_ls2cdb  = '0;
        bus.stop_rob2cdb  = 0;
        repeat (3) @(negedge clk);
        model_reset();
        step(0, 1);
        step(0, 0);
        check("rst_valid",  64'(bus.valid_cdb), 64'(0));
        check("rst_stop_i", 64'(bus.stop_cdb2int), 64'(0));
        check("rst_stop_l", 64'(bus.stop_cdb2ls), 64'(0));
        check("rst_result", bus.result_cdb, 64'(0));

        // Single bypass
        pend_i.push_back(mk(64'h2A, 6'd5, 6'd3));
        step(0, 0);
        check("byp_valid",  64'(bus.valid_cdb), 64'(1));
        check("byp_result", bus.result_cdb, 64'h2A);
        check("byp_rd",     64'(bus.rd_cdb), 64'(5));
        check("byp_tag",    64'(bus.tag_cdb), 64'(3));
        check("byp_src",    64'(bus.src_cdb), 64'(0));
        step(0, 0);
        check("byp_done",   64'(bus.valid_cdb), 64'(0));

        // Tie after reset: INT first
        step(0, 1);
        pend_i.push_back(mk(64'h11, 6'd0, 6'd1));
        pend_l.push_back(mk(64'h22, 6'd0, 6'd2));
        step(0, 0);
        check("tie0_result", bus.result_cdb, 64'h11);
        check("tie0_src",    64'(bus.src_cdb), 64'(0));
        step(0, 0);
        check("tie1_result", bus.result_cdb, 64'h22);
        check("tie1_src",    64'(bus.src_cdb), 64'(1));
        step(0, 0);
        check("tie_done",    64'(bus.valid_cdb), 64'(0));

        // Fairness
        step(0, 1);
        for (int k = 0; k < 8; k++) begin
            pend_i.push_back(rnd_beat(6'(k)));
            pend_l.push_back(rnd_beat(6'(8 + k)));
        end
        log_q.delete();
        repeat (22) step(0, 0);
        check("fair_count", 64'(log_q.size()), 64'(16));
        for (int k = 0; k < 16; k++) begin
            got = (k < log_q.size()) ? log_q[k] : 7'h7f;
            check("fair_entry", 64'(got), 64'({1'(k % 2), 6'((k % 2 == 0) ? k / 2 : 8 + k / 2)}));
        end

        // Back-pressure from the ROB
        step(0, 1);
        for (int k = 0; k < 4; k++) pend_i.push_back(rnd_beat(6'(20 + k)));
        repeat (3) step(1, 0);
        check("bp_stop",  64'(bus.stop_cdb2int), 64'(1));
        check("bp_tag",   64'(bus.tag_cdb), 64'(20));
        step(1, 0);
        check("bp_hold",  64'(bus.tag_cdb), 64'(20));
        log_q.delete();
        repeat (6) step(0, 0);
        check("bp_count", 64'(log_q.size()), 64'(4));
        for (int k = 0; k < 4; k++) begin
            got = (k < log_q.size()) ? log_q[k] : 7'h7f;
            check("bp_entry", 64'(got), 64'({1'b0, 6'(20 + k)}));
        end

        // Randomized traffic with occasional ROB stalls and resets
        step(0, 1);
        for (int c = 0; c < 600; c++) begin
            if (pend_i.size() < 3 && ($urandom % 3) != 0) pend_i.push_back(rnd_beat(6'($urandom)));
            if (pend_l.size() < 3 && ($urandom % 3) != 0) pend_l.push_back(rnd_beat(6'($urandom)));
            step(($urandom % 10) < 3, ($urandom % 150) == 0);
        end
        repeat (12) step(0, 0);

        // Reset with both FIFOs full
        step(0, 1);
        for (int k = 0; k < 4; k++) begin
            pend_i.push_back(rnd_beat(6'(k)));
            pend_l.push_back(rnd_beat(6'(32 + k)));
        end
        repeat (6) step(1, 0);
        check("full_stop_i", 64'(bus.stop_cdb2int), 64'(1));
        check("full_stop_l", 64'(bus.stop_cdb2ls), 64'(1));
        step(1, 1);
        check("mid_rst_valid",  64'(bus.valid_cdb), 64'(0));
        check("mid_rst_stop_i", 64'(bus.stop_cdb2int), 64'(0));
        check("mid_rst_stop_l", 64'(bus.stop_cdb2ls), 64'(0));
        for (int k = 0; k < 4; k++) begin
            step(0, 0);
            check("no_stale", 64'(bus.valid_cdb), 64'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
